// File: rtl/lm75_reader.sv
// lm75_reader: periodically reads the LM75 temperature register over I2C
// and publishes integer Celsius and Fahrenheit values.
// Bus timing is built from quarter-bit ticks; every bit slot is four ticks.
module lm75_reader #(
  parameter int         CLK_FREQ     = 25_000_000,
  parameter int         I2C_FREQ     = 100_000,
  parameter logic [6:0] DEV_ADDR     = 7'h48,
  parameter int         PWRUP_CYCLES = 25_000,
  parameter int         POLL_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        I2C_SDA,
  inout  wire        I2C_SCL,
  output logic [7:0] c_data,
  output logic [9:0] f_data,
  output logic       data_valid,
  output logic       i2c_err
);

  localparam int QTR  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW   = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int WMAX = (PWRUP_CYCLES > POLL_CYCLES) ? PWRUP_CYCLES : POLL_CYCLES;
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [7:0]    ADDR_W   = {DEV_ADDR, 1'b0};
  localparam logic [7:0]    ADDR_R   = {DEV_ADDR, 1'b1};
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);
  localparam logic [WW-1:0] W_PWRUP  = WW'(PWRUP_CYCLES - 1);
  localparam logic [WW-1:0] W_POLL   = WW'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_WAIT, S_START, S_TX_BYTE, S_RX_ACK, S_RESTART,
    S_RX_BYTE, S_TX_ACK, S_STOP, S_UPDATE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ph;
  logic [QW-1:0]   r_qcnt;
  logic [WW-1:0]   r_wait;
  logic [2:0]      r_bit;
  logic [2:0]      r_byte;
  logic [7:0]      r_sh;
  logic [7:0]      r_msb;
  logic            r_nack;
  logic            r_sda_lo;
  logic            r_scl_lo;

  logic            w_tick;
  logic            w_sda_in;
  logic            w_bit_slot;
  logic signed [11:0] w_c_ext;
  logic signed [11:0] w_c9;
  logic signed [11:0] w_q;
  logic signed [9:0]  w_f;

  // Open-drain drivers: only ever pull low or release.
  assign I2C_SDA  = r_sda_lo ? 1'b0 : 1'bz;
  assign I2C_SCL  = r_scl_lo ? 1'b0 : 1'bz;
  assign w_sda_in = I2C_SDA;

  assign w_tick     = (r_qcnt == QTR_LAST);
  assign w_bit_slot = (r_state == S_TX_BYTE) || (r_state == S_RX_ACK) ||
                      (r_state == S_RX_BYTE) || (r_state == S_TX_ACK);

  // Fahrenheit conversion; signed division truncates toward zero.
  assign w_c_ext = {{4{r_msb[7]}}, r_msb};
  assign w_c9    = w_c_ext * 12'sd9;
  assign w_q     = w_c9 / 12'sd5;
  assign w_f     = 10'(w_q + 12'sd32);

  // Quarter-bit tick divider, held at zero while idle so a transaction starts phase-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcnt <= '0;
    end else if (r_state == S_WAIT || w_tick) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= r_qcnt + QW'(1);
    end
  end

  // Transaction sequencer with registered bus drivers and outputs.
  // Bit slots: tick0 releases SCL, tick1 samples SDA (SCL-high midpoint),
  // tick2 pulls SCL low, tick3 ends the slot and sets up SDA for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_WAIT;
      r_ph       <= '0;
      r_wait     <= W_PWRUP;
      r_bit      <= '0;
      r_byte     <= '0;
      r_sh       <= '0;
      r_msb      <= '0;
      r_nack     <= 1'b0;
      r_sda_lo   <= 1'b0;
      r_scl_lo   <= 1'b0;
      c_data     <= '0;
      f_data     <= '0;
      data_valid <= 1'b0;
      i2c_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (w_bit_slot && w_tick) begin
        r_ph <= r_ph + 2'd1;
        if (r_ph == 2'd0) r_scl_lo <= 1'b0;
        if (r_ph == 2'd2) r_scl_lo <= 1'b1;
      end
      case (r_state)
        S_WAIT: begin
          r_sda_lo <= 1'b0;
          r_scl_lo <= 1'b0;
          if (r_wait == '0) begin
            r_state  <= S_START;
            r_ph     <= '0;
            r_nack   <= 1'b0;
            r_sda_lo <= 1'b1;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        S_START: if (w_tick) begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd1) r_scl_lo <= 1'b1;
          if (r_ph == 2'd3) begin
            r_state  <= S_TX_BYTE;
            r_byte   <= 3'd0;
            r_bit    <= 3'd7;
            r_sh     <= ADDR_W;
            r_sda_lo <= ~ADDR_W[7];
          end
        end
        S_TX_BYTE: if (w_tick && r_ph == 2'd3) begin
          if (r_bit == 3'd0) begin
            r_state  <= S_RX_ACK;
            r_sda_lo <= 1'b0;
          end else begin
            r_bit    <= r_bit - 3'd1;
            r_sh     <= {r_sh[6:0], 1'b0};
            r_sda_lo <= ~r_sh[6];
          end
        end
        S_RX_ACK: if (w_tick) begin
          if (r_ph == 2'd1) r_nack <= w_sda_in;
          if (r_ph == 2'd3) begin
            if (r_nack) begin
              r_state  <= S_STOP;
              r_sda_lo <= 1'b1;
              i2c_err  <= 1'b1;
            end else if (r_byte == 3'd0) begin
              r_state  <= S_TX_BYTE;
              r_byte   <= 3'd1;
              r_bit    <= 3'd7;
              r_sh     <= 8'h00;
              r_sda_lo <= 1'b1;
            end else if (r_byte == 3'd1) begin
              r_state  <= S_RESTART;
              r_byte   <= 3'd2;
              r_sda_lo <= 1'b0;
            end else begin
              r_state  <= S_RX_BYTE;
              r_byte   <= 3'd3;
              r_bit    <= 3'd7;
              r_sda_lo <= 1'b0;
            end
          end
        end
        S_RESTART: if (w_tick) begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd0) r_scl_lo <= 1'b0;
          if (r_ph == 2'd1) r_sda_lo <= 1'b1;
          if (r_ph == 2'd2) r_scl_lo <= 1'b1;
          if (r_ph == 2'd3) begin
            r_state  <= S_TX_BYTE;
            r_bit    <= 3'd7;
            r_sh     <= ADDR_R;
            r_sda_lo <= ~ADDR_R[7];
          end
        end
        S_RX_BYTE: if (w_tick) begin
          if (r_ph == 2'd1) r_sh <= {r_sh[6:0], w_sda_in};
          if (r_ph == 2'd3) begin
            if (r_bit == 3'd0) begin
              r_state  <= S_TX_ACK;
              r_sda_lo <= (r_byte == 3'd3);
              if (r_byte == 3'd3) r_msb <= r_sh;
            end else begin
              r_bit <= r_bit - 3'd1;
            end
          end
        end
        S_TX_ACK: if (w_tick && r_ph == 2'd3) begin
          if (r_byte == 3'd3) begin
            r_state  <= S_RX_BYTE;
            r_byte   <= 3'd4;
            r_bit    <= 3'd7;
            r_sda_lo <= 1'b0;
          end else begin
            r_state  <= S_STOP;
            r_sda_lo <= 1'b1;
          end
        end
        S_STOP: if (w_tick) begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd0) r_scl_lo <= 1'b0;
          if (r_ph == 2'd1) r_sda_lo <= 1'b0;
          if (r_ph == 2'd3) begin
            if (r_nack) begin
              r_state <= S_WAIT;
              r_wait  <= W_POLL;
            end else begin
              r_state <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          c_data     <= r_msb;
          f_data     <= w_f;
          data_valid <= 1'b1;
          i2c_err    <= 1'b0;
          r_state    <= S_WAIT;
          r_wait     <= W_POLL;
        end
        default: begin
          r_state <= S_WAIT;
          r_wait  <= W_POLL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lm75_reader.sv
// Bench for lm75_reader: behavioural LM75 slave on pulled-up lines, a bus
// monitor for START/STOP/SCL timing, and a temperature reference model.
module tb_lm75_reader;

  localparam int PWRUP = 300;
  localparam int POLL  = 1000;
  localparam int QTR   = 25_000_000 / (4 * 100_000);
  // START + 5 byte frames of 9 bit-times + RESTART + STOP = 48 bit-times
  localparam int TXN   = 48 * 4 * QTR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire        sda;
  wire        scl;
  logic [7:0] c_data;
  logic [9:0] f_data;
  logic       data_valid;
  logic       i2c_err;

  pullup (sda);
  pullup (scl);

  lm75_reader #(.PWRUP_CYCLES(PWRUP), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .rst(rst), .I2C_SDA(sda), .I2C_SCL(scl),
    .c_data(c_data), .f_data(f_data), .data_valid(data_valid), .i2c_err(i2c_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic       s_lo = 1'b0;
  bit         present = 1'b1;
  logic [7:0] rd_msb = 8'h00;
  logic [7:0] rd_lsb = 8'h00;
  logic [7:0] wbytes[$];
  int         mode = 0;   // 0 idle, 1 address, 2 write data, 3 read data
  int         nxt = 0;
  int         bitn = 0;
  int         rd_idx = 0;
  logic [7:0] sh = '0;
  logic [7:0] cur = '0;
  logic       m_ack = 1'b1;
  logic       q_scl = 1'b1;
  logic       q_sda = 1'b1;

  assign sda = (s_lo && !rst) ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (rst) begin
      mode = 0; bitn = 0; s_lo = 1'b0;
    end else if (q_scl && scl && q_sda && !sda) begin
      mode = 1; bitn = 0; s_lo = 1'b0;
    end else if (q_scl && scl && !q_sda && sda) begin
      mode = 0; bitn = 0; s_lo = 1'b0;
    end else if (mode != 0) begin
      if (!q_scl && scl) begin
        bitn++;
        if (bitn <= 8 && mode != 3) sh = {sh[6:0], sda};
        if (bitn == 9 && mode == 3) m_ack = sda;
      end else if (q_scl && !scl) begin
        if (bitn == 8) begin
          if (mode == 3) s_lo = 1'b0;
          else begin
            wbytes.push_back(sh);
            s_lo = present && (mode == 2 || sh[7:1] == 7'h48);
            nxt  = !s_lo ? 0 : ((mode == 1) ? (sh[0] ? 3 : 2) : 2);
          end
        end else if (bitn == 9) begin
          bitn = 0;
          if (mode == 3) begin
            if (m_ack == 1'b0) begin
              rd_idx++;
              cur  = (rd_idx == 1) ? rd_lsb : 8'hFF;
              s_lo = ~cur[7];
            end else begin
              mode = 0; s_lo = 1'b0;
            end
          end else begin
            mode = nxt; s_lo = 1'b0;
            if (mode == 3) begin
              rd_idx = 0; cur = rd_msb; s_lo = ~cur[7];
            end
          end
        end else if (mode == 3) begin
          s_lo = ~cur[7 - bitn];
        end
      end
    end
    q_scl = scl;
    q_sda = sda;
  end

  // ---------------- bus / output monitor ----------------
  int   start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
  int   rise_prev = -1, gap_min = 1_000_000, gap_max = 0;
  int   dv_cnt = 0, dv_cyc = 0;
  bit   in_txn = 1'b0;
  logic p_scl = 1'b1, p_sda = 1'b1;

  always @(negedge clk) begin
    if (rst) in_txn = 1'b0;
    if (p_scl && scl && p_sda && !sda) begin
      start_cnt++; start_cyc = cyc;
      if (!in_txn) rise_prev = -1;
      in_txn = 1'b1;
    end else if (p_scl && scl && !p_sda && sda) begin
      stop_cnt++; stop_cyc = cyc;
    end
    if (!p_scl && scl && in_txn) begin
      if (rise_prev >= 0) begin
        if (cyc - rise_prev < gap_min) gap_min = cyc - rise_prev;
        if (cyc - rise_prev > gap_max) gap_max = cyc - rise_prev;
      end
      rise_prev = cyc;
    end
    if (p_scl && scl && !p_sda && sda) in_txn = 1'b0;
    if (data_valid) begin dv_cnt++; dv_cyc = cyc; end
    p_scl = scl;
    p_sda = sda;
  end

  // ---------------- reference model and checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int ref_c(input logic [7:0] msb);
    return (msb >= 8'd128) ? int'(msb) - 256 : int'(msb);
  endfunction

  function automatic int ref_f(input int c);
    int t;
    t = c * 9;
    return ((t >= 0) ? (t / 5) : -((-t) / 5)) + 32;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input int prev, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TXN + POLL + PWRUP + 500; i++) begin
      @(negedge clk);
      if (dv_cnt > prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (start_cnt > prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_bytes(input string tag, input int base);
    check({tag, "_nbytes"}, wbytes.size() - base, 3);
    if (wbytes.size() >= base + 3) begin
      check({tag, "_b0"}, int'(wbytes[base]),     'h90);
      check({tag, "_b1"}, int'(wbytes[base + 1]), 'h00);
      check({tag, "_b2"}, int'(wbytes[base + 2]), 'h91);
    end
  endtask

  initial begin
    bit ok;
    int rel, s0, p0, d0, w0, dvc, c;

    present = 1'b1; rd_msb = 8'h19; rd_lsb = 8'h80;
    repeat (5) @(negedge clk);
    check("rst_c",   int'(c_data), 0);
    check("rst_f",   int'(f_data), 0);
    check("rst_dv",  int'(data_valid), 0);
    check("rst_err", int'(i2c_err), 0);
    check("rst_sda", int'(sda), 1);
    check("rst_scl", int'(scl), 1);

    // T1: 25.5 degC, first transaction after power-up wait
    s0 = start_cnt; p0 = stop_cnt; d0 = dv_cnt; w0 = wbytes.size();
    rst = 1'b0; rel = cyc;
    wait_start(s0, PWRUP + 50, ok);
    check("pwrup_start_seen", int'(ok), 1);
    check("pwrup_delay", start_cyc - rel, PWRUP);
    wait_dv(d0, ok);
    check("t1_dv_seen", int'(ok), 1);
    @(negedge clk);
    check("t1_dv_width", int'(data_valid), 0);
    check("t1_c", int'($signed(c_data)), ref_c(8'h19));
    check("t1_f", int'($signed(f_data)), ref_f(ref_c(8'h19)));
    check("t1_err", int'(i2c_err), 0);
    check("t1_dv_count", dv_cnt - d0, 1);
    check("t1_starts", start_cnt - s0, 2);
    check("t1_stops", stop_cnt - p0, 1);
    check_bytes("t1", w0);
    check("scl_period_min", gap_min, 4 * QTR);
    check("scl_period_max", gap_max, 4 * QTR);

    // T2: 30 degC on the next poll; pulse spacing
    rd_msb = 8'h1E; rd_lsb = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
    dvc = dv_cyc; d0 = dv_cnt;
    wait_dv(d0, ok);
    check("t2_dv_seen", int'(ok), 1);
    check("t2_spacing", dv_cyc - dvc, TXN + 1 + POLL);
    check("t2_c", int'($signed(c_data)), 30);
    check("t2_f", int'($signed(f_data)), ref_f(30));

    // T3: no slave -> NACK on address, outputs held, retry after poll
    present = 1'b0;
    s0 = start_cnt; p0 = stop_cnt; d0 = dv_cnt; w0 = wbytes.size();
    ok = 1'b0;
    for (int i = 0; i < TXN + POLL + 500; i++) begin
      @(negedge clk);
      if (stop_cnt > p0) begin ok = 1'b1; break; end
    end
    check("t3_stop_seen", int'(ok), 1);
    repeat (2 * QTR + 5) @(negedge clk);
    check("t3_err", int'(i2c_err), 1);
    check("t3_c_held", int'($signed(c_data)), 30);
    check("t3_f_held", int'($signed(f_data)), ref_f(30));
    check("t3_no_dv", dv_cnt - d0, 0);
    check("t3_starts", start_cnt - s0, 1);
    check("t3_addr_byte", (wbytes.size() > w0) ? int'(wbytes[w0]) : -1, 'h90);
    wait_start(start_cnt, POLL + 2 * QTR + 50, ok);
    present = 1'b1;
    check("t3_retry_seen", int'(ok), 1);
    check("t3_retry_delay", start_cyc - stop_cyc, POLL + 2 * QTR);
    check("t3_err_held", int'(i2c_err), 1);

    // T4: random temperature, slave back -> error cleared
    c = int'($urandom_range(0, 180)) - 55;
    rd_msb = 8'(c); rd_lsb = 8'($urandom_range(0, 255));
    d0 = dv_cnt;
    wait_dv(d0, ok);
    check("t4_dv_seen", int'(ok), 1);
    check("t4_c", int'($signed(c_data)), c);
    check("t4_f", int'($signed(f_data)), ref_f(c));
    check("t4_err_cleared", int'(i2c_err), 0);

    // T5: reset during MSB read
    rd_msb = 8'($urandom_range(1, 125));
    ok = 1'b0;
    for (int i = 0; i < TXN + POLL + 500; i++) begin
      @(negedge clk);
      if (mode == 3 && rd_idx == 0 && bitn == 3 && !scl) begin ok = 1'b1; break; end
    end
    check("t5_msb_phase_seen", int'(ok), 1);
    p0 = stop_cnt; d0 = dv_cnt;
    rst = 1'b1;
    #1;
    check("t5_rst_c", int'(c_data), 0);
    check("t5_rst_f", int'(f_data), 0);
    check("t5_rst_dv", int'(data_valid), 0);
    check("t5_rst_sda", int'(sda), 1);
    check("t5_rst_scl", int'(scl), 1);
    rd_msb = 8'hD8; rd_lsb = 8'h00;
    repeat (4) @(negedge clk);
    check("t5_no_stop", stop_cnt - p0, 0);

    // T6: fresh transaction after reset release, -40 degC
    s0 = start_cnt; w0 = wbytes.size();
    rst = 1'b0; rel = cyc;
    wait_start(s0, PWRUP + 50, ok);
    check("t6_start_seen", int'(ok), 1);
    check("t6_pwrup_delay", start_cyc - rel, PWRUP);
    wait_dv(d0, ok);
    check("t6_dv_seen", int'(ok), 1);
    check("t6_dv_count", dv_cnt - d0, 1);
    check("t6_c_hex", int'(c_data), 'hD8);
    check("t6_f_hex", int'(f_data), 'h3D8);
    check("t6_f_model", int'($signed(f_data)), ref_f(ref_c(8'hD8)));
    check("t6_err", int'(i2c_err), 0);
    check_bytes("t6", w0);
    check("final_scl_period_min", gap_min, 4 * QTR);
    check("final_scl_period_max", gap_max, 4 * QTR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
